mux_nway_rr: RTL and testbench

Parametrised N-channel, W-bit registered multiplexer with a valid/ready handshake on every input and on the output. A fixed-select mode routes the channel chosen by `sel`. A round-robin mode arbitrates fairly among all valid channels. The block is the sequential, multi-bit successor of the 4-way 1-bit combinational mux. It sits between several producers and one consumer in the datapath and provides one cycle of registered latency and back-pressure.

---
 rtl/mux_nway_rr.sv | 131 +++++++++++++
 tb/tb_mux_nway_rr.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_nway_rr.sv
// mux_nway_rr: N-channel, W-bit registered multiplexer with valid/ready on every
// input and on the output. mode=0 routes the channel chosen by sel; mode=1
// arbitrates round-robin among valid channels starting at an internal pointer.
// One output register stage gives one cycle of latency and full throughput.
//
// Optional feature macro: MUX_NWAY_RR_COUNT_EN adds per-channel saturating
// 8-bit transfer counters on port grant_cnt.
//
// Ports:
//   clock      in   sole clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   in_data    in   CHANNELS*WIDTH, channel i at [i*WIDTH +: WIDTH]
//   in_valid   in   per-channel valid
//   in_ready   out  per-channel ready (combinational, at most one bit high)
//   sel        in   channel select, used when mode=0
//   mode       in   0 = fixed select, 1 = round-robin
//   out_data   out  registered data
//   out_chan   out  source channel of out_data
//   out_valid  out  output register holds data
//   out_ready  in   consumer accepts
//   grant_cnt  out  CHANNELS*8 transfer counters (MUX_NWAY_RR_COUNT_EN only)
module mux_nway_rr #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [CHANNELS*WIDTH-1:0]     in_data,
  input  logic [CHANNELS-1:0]           in_valid,
  output logic [CHANNELS-1:0]           in_ready,
  input  logic [$clog2(CHANNELS)-1:0]   sel,
  input  logic                          mode,
  output logic [WIDTH-1:0]              out_data,
  output logic [$clog2(CHANNELS)-1:0]   out_chan,
  output logic                          out_valid,
  input  logic                          out_ready
`ifdef MUX_NWAY_RR_COUNT_EN
  ,
  output logic [CHANNELS*8-1:0]         grant_cnt
`endif
);

  localparam int unsigned SEL_W = $clog2(CHANNELS);
  localparam int unsigned CNT_W = 8;

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] grant;
  logic             grant_ok;
  logic             load;
  logic             xfer;
  logic [WIDTH-1:0] grant_data;

  // Output register can accept a new word when empty or being drained.
  assign load = !out_valid || out_ready;
  assign xfer = grant_ok && load;

  // Grant selection: fixed channel in mode 0, first valid channel at or after ptr in mode 1.
  always_comb begin : grant_sel
    int unsigned idx;
    grant    = '0;
    grant_ok = 1'b0;
    idx      = 0;
    if (!mode) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          grant    = SEL_W'(i);
          grant_ok = 1'b1;
        end
      end
    end else begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        idx = 32'(ptr) + k;
        if (idx >= CHANNELS) begin
          idx = idx - CHANNELS;
        end
        if (!grant_ok && in_valid[idx]) begin
          grant    = SEL_W'(idx);
          grant_ok = 1'b1;
        end
      end
    end
  end

  // One-hot ready to the granted producer and the data it offers.
  always_comb begin
    in_ready   = '0;
    grant_data = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (grant == SEL_W'(i)) begin
        in_ready[i] = xfer;
        grant_data  = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_data  <= '0;
      out_chan  <= '0;
      out_valid <= 1'b0;
      ptr       <= '0;
    end else if (load) begin
      if (grant_ok) begin
        out_data  <= grant_data;
        out_chan  <= grant;
        out_valid <= 1'b1;
        if (mode) begin
          ptr <= (grant == SEL_W'(CHANNELS - 1)) ? '0 : grant + SEL_W'(1);
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef MUX_NWAY_RR_COUNT_EN
  // Per-channel saturating transfer counters.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_cnt
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        grant_cnt[i*CNT_W +: CNT_W] <= '0;
      end else if (xfer && grant == SEL_W'(i) &&
                   grant_cnt[i*CNT_W +: CNT_W] != {CNT_W{1'b1}}) begin
        grant_cnt[i*CNT_W +: CNT_W] <= grant_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_mux_nway_rr.sv
// Bench for mux_nway_rr (WIDTH=8, CHANNELS=4): directed vectors with literal
// expectations, plus a per-cycle comparison against a behavioural model.
module tb_mux_nway_rr;

  localparam int CH = 4;
  localparam int W  = 8;

  logic            clock;
  logic            reset_n;
  logic [CH*W-1:0] in_data;
  logic [CH-1:0]   in_valid;
  logic [CH-1:0]   in_ready;
  logic [1:0]      sel;
  logic            mode;
  logic [W-1:0]    out_data;
  logic [1:0]      out_chan;
  logic            out_valid;
  logic            out_ready;
`ifdef MUX_NWAY_RR_COUNT_EN
  logic [CH*8-1:0] grant_cnt;
`endif

  mux_nway_rr #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .mode      (mode),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef MUX_NWAY_RR_COUNT_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the output register contents and the arbitration pointer.
  int          m_ptr;
  bit          m_valid;
  int          m_data;
  int          m_chan;
  int          m_cnt [CH];

  // Channel that must be granted now, or -1.
  function automatic int exp_grant();
    int c;
    if (mode == 1'b0) begin
      if (int'(sel) < CH && in_valid[sel]) return int'(sel);
      return -1;
    end
    for (int k = 0; k < CH; k++) begin
      c = (m_ptr + k) % CH;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic int exp_ready();
    int g;
    g = exp_grant();
    if ((!m_valid || out_ready) && g >= 0) return 1 << g;
    return 0;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    int g;
    if (!reset_n) begin
      m_ptr = 0; m_valid = 0; m_data = 0; m_chan = 0;
      for (int i = 0; i < CH; i++) m_cnt[i] = 0;
    end else if (!m_valid || out_ready) begin
      g = exp_grant();
      if (g >= 0) begin
        m_data  = int'(in_data[g*W +: W]);
        m_chan  = g;
        m_valid = 1;
        if (m_cnt[g] < 255) m_cnt[g] = m_cnt[g] + 1;
        if (mode) m_ptr = (g + 1) % CH;
      end else begin
        m_valid = 0;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clock) begin
    check("model_in_ready",  32'(in_ready),  32'(exp_ready()));
    check("model_out_valid", 32'(out_valid), 32'(m_valid));
    check("model_out_data",  32'(out_data),  32'(m_data));
    check("model_out_chan",  32'(out_chan),  32'(m_chan));
`ifdef MUX_NWAY_RR_COUNT_EN
    for (int i = 0; i < CH; i++)
      check("model_grant_cnt", 32'(grant_cnt[i*8 +: 8]), 32'(m_cnt[i]));
`endif
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  int rr_exp [5] = '{0, 1, 2, 3, 0};

  initial begin
    reset_n   = 1'b0;
    in_data   = '0;
    in_valid  = '0;
    sel       = '0;
    mode      = 1'b0;
    out_ready = 1'b0;
    #1;
    check("reset_out_valid", 32'(out_valid), 32'h0);
    check("reset_out_data",  32'(out_data),  32'h0);
    check("reset_out_chan",  32'(out_chan),  32'h0);
    step();
    step();
    reset_n = 1'b1;

    // Fixed select
    in_data   = 32'h44332211;
    in_valid  = 4'hF;
    sel       = 2'd2;
    out_ready = 1'b1;
    #1;
    check("fixed_in_ready", 32'(in_ready), 32'h4);
    step();
    check("fixed_data_sel2", 32'(out_data), 32'h33);
    check("fixed_chan_sel2", 32'(out_chan), 32'h2);
    check("fixed_valid",     32'(out_valid), 32'h1);
    sel = 2'd3;
    step();
    check("fixed_data_sel3", 32'(out_data), 32'h44);
    check("fixed_chan_sel3", 32'(out_chan), 32'h3);

    // Selected channel not valid
    sel      = 2'd2;
    in_valid = 4'b1011;
    #1;
    check("invsel_in_ready", 32'(in_ready), 32'h0);
    step();
    check("invsel_out_valid", 32'(out_valid), 32'h0);
    check("invsel_data_hold", 32'(out_data), 32'h44);

    // Round-robin, all valid, no bubbles
    mode     = 1'b1;
    in_valid = 4'hF;
    for (int i = 0; i < 5; i++) begin
      step();
      check("rr_out_chan",  32'(out_chan),  32'(rr_exp[i]));
      check("rr_out_valid", 32'(out_valid), 32'h1);
    end

    // Back-pressure: channel 1 only
    in_valid = 4'b0010;
    in_data  = 32'h0000A500;
    step();
    check("bp_load_data", 32'(out_data), 32'hA5);
    out_ready = 1'b0;
    in_data   = 32'h00005A00;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_in_ready", 32'(in_ready), 32'h0);
      step();
      check("bp_hold_data",  32'(out_data),  32'hA5);
      check("bp_hold_valid", 32'(out_valid), 32'h1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'h2);
    step();
    check("bp_reload_data",  32'(out_data),  32'h5A);
    check("bp_reload_valid", 32'(out_valid), 32'h1);
    check("bp_reload_chan",  32'(out_chan),  32'h1);

    // Asynchronous reset mid-cycle with a held word
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'h0);
    check("async_rst_data",  32'(out_data),  32'h0);
    check("async_rst_chan",  32'(out_chan),  32'h0);
    step();
    reset_n = 1'b1;

    // Saturating counters: 300 transfers from channel 0
    mode      = 1'b0;
    sel       = 2'd0;
    in_valid  = 4'b0001;
    in_data   = 32'h00000077;
    out_ready = 1'b1;
    repeat (300) step();
    check("cnt_out_data", 32'(out_data), 32'h77);
`ifdef MUX_NWAY_RR_COUNT_EN
    check("cnt_ch0_sat", 32'(grant_cnt[7:0]),   32'd255);
    check("cnt_ch1",     32'(grant_cnt[15:8]),  32'd0);
    check("cnt_ch2",     32'(grant_cnt[23:16]), 32'd0);
    check("cnt_ch3",     32'(grant_cnt[31:24]), 32'd0);
`endif
    in_valid = '0;
    step();
    check("drain_out_valid", 32'(out_valid), 32'h0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
